// File: rtl/up_trace_capture.sv
// Bus-transaction capture engine: frames CPU bus accesses, matches them against
// NCH address-range triggers and queues timestamped hits in a FIFO for readout.
module up_trace_capture #(
  parameter int AW    = 14,
  parameter int DW    = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int TSW   = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int EW   = CHW + 1 + TSW + AW + DW,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic              up_clk,
  input  logic              up_rst,
  input  logic              up_csn,
  input  logic              up_wbe,
  input  logic [AW-1:0]     up_addr,
  input  logic [DW-1:0]     up_data_io,
  input  logic              mon_en,
  input  logic [NCH*AW-1:0] trig_lo,
  input  logic [NCH*AW-1:0] trig_hi,
  input  logic [NCH*2-1:0]  trig_mode,
  input  logic              fifo_clr,
  input  logic              ovf_clr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [EW-1:0]     rd_data,
  output logic [LW-1:0]     level,
  output logic              ovf,
  output logic [7:0]        drop_cnt
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } frame_state_t;

  frame_state_t state_q, state_d;

  logic          prev_csn_q, prev_csn_d;
  logic          armed_q, armed_d;
  logic          wbe_q, wbe_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [TSW-1:0] ts_q, ts_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic            start_cyc;
  logic            end_cyc;
  logic [NCH-1:0]  chan_hit;
  logic            hit_any;
  logic [CHW-1:0]  hit_chan;
  logic            capture;
  logic [EW-1:0]   entry;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Framing. armed_q stays low after reset until csn is seen high, so an
  // access already underway at reset release is never framed.
  always_comb begin
    state_d    = state_q;
    prev_csn_d = up_csn;
    armed_d    = armed_q | up_csn;
    wbe_d      = wbe_q;
    addr_d     = addr_q;
    data_d     = data_q;
    start_cyc  = 1'b0;
    end_cyc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!up_csn && prev_csn_q && armed_q) begin
          start_cyc = 1'b1;
          state_d   = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (up_csn) begin
          end_cyc = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!up_csn && (start_cyc || state_q == S_ACTIVE)) begin
      wbe_d  = up_wbe;
      addr_d = up_addr;
      data_d = up_data_io;
    end
  end

  // Per-channel range and direction match on the registered transaction.
  always_comb begin
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic          dir_ok;
    chan_hit = '0;
    lo       = '0;
    hi       = '0;
    dir_ok   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      lo          = trig_lo[k*AW +: AW];
      hi          = trig_hi[k*AW +: AW];
      dir_ok      = wbe_q ? trig_mode[2*k+1] : trig_mode[2*k];
      chan_hit[k] = (addr_q >= lo) && (addr_q <= hi) && dir_ok;
    end
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit_any  = 1'b0;
    hit_chan = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (chan_hit[k]) begin
        hit_any  = 1'b1;
        hit_chan = CHW'(k);
      end
    end
  end

  assign capture = end_cyc && mon_en && hit_any;
  assign entry   = {hit_chan, ~wbe_q, ts_q, addr_q, data_q};
  assign ts_d    = ts_q + 1'b1;

  // FIFO control: a full FIFO still accepts a push when the head leaves in
  // the same cycle; a flush swallows any push without counting it as a drop.
  always_comb begin
    full     = (count_q == LW'(DEPTH));
    pop      = (count_q != '0) && rd_ready;
    push     = capture && (!full || pop) && !fifo_clr;
    drop     = capture && full && !pop && !fifo_clr;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state_q    <= S_IDLE;
      prev_csn_q <= 1'b1;
      armed_q    <= 1'b0;
      wbe_q      <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      prev_csn_q <= prev_csn_d;
      armed_q    <= armed_d;
      wbe_q      <= wbe_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = count_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_up_trace_capture.sv
// Bench for up_trace_capture: directed scenarios, a vector table and random
// traffic, all checked every cycle against a queue-based reference model.
module tb_up_trace_capture;

  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int NCH    = 4;
  localparam int DEPTH  = 16;
  localparam int TSW    = 4;
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW     = CHW + 1 + TSW + AW + DW;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int TS_LSB = AW + DW;
  localparam int WR_BIT = TSW + AW + DW;
  localparam int CH_LSB = WR_BIT + 1;

  logic              up_clk;
  logic              up_rst;
  logic              up_csn;
  logic              up_wbe;
  logic [AW-1:0]     up_addr;
  logic [DW-1:0]     up_data_io;
  logic              mon_en;
  logic [NCH*AW-1:0] trig_lo;
  logic [NCH*AW-1:0] trig_hi;
  logic [NCH*2-1:0]  trig_mode;
  logic              fifo_clr;
  logic              ovf_clr;
  logic              rd_valid;
  logic              rd_ready;
  logic [EW-1:0]     rd_data;
  logic [LW-1:0]     level;
  logic              ovf;
  logic [7:0]        drop_cnt;

  up_trace_capture #(
    .AW(AW), .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .TSW(TSW)
  ) dut (
    .up_clk(up_clk), .up_rst(up_rst), .up_csn(up_csn), .up_wbe(up_wbe),
    .up_addr(up_addr), .up_data_io(up_data_io), .mon_en(mon_en),
    .trig_lo(trig_lo), .trig_hi(trig_hi), .trig_mode(trig_mode),
    .fifo_clr(fifo_clr), .ovf_clr(ovf_clr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .level(level), .ovf(ovf),
    .drop_cnt(drop_cnt)
  );

  // Clock and cycle counter (cycles since reset release = expected timestamp).
  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  int cyc;
  always @(posedge up_clk or posedge up_rst) begin
    if (up_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests;
  int fails;

  // Reference model state.
  logic [EW-1:0] exp_q[$];
  bit            m_ovf;
  int            m_drop;
  logic [AW-1:0] t_lo   [NCH];
  logic [AW-1:0] t_hi   [NCH];
  logic [1:0]    t_mode [NCH];

  bit            end_now;
  bit            t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  int            last_e_ts;
  bit            rand_mode;

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    bit             exp_valid;
    logic [CHW-1:0] exp_chan;
  } vec_t;

  vec_t vecs[6];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_hit(logic [AW-1:0] a, bit wr);
    for (int k = 0; k < NCH; k++) begin
      if (t_lo[k] <= a && a <= t_hi[k] && (wr ? t_mode[k][0] : t_mode[k][1]))
        return k;
    end
    return -1;
  endfunction

  task automatic set_trig();
    for (int k = 0; k < NCH; k++) begin
      trig_lo[k*AW +: AW] = t_lo[k];
      trig_hi[k*AW +: AW] = t_hi[k];
      trig_mode[k*2 +: 2] = t_mode[k];
    end
  endtask

  // One bus cycle: called at a negedge with inputs set; checks outputs against
  // the model, advances the model, and returns at the following negedge.
  task automatic step();
    int             sz;
    int             ch;
    bit             pop;
    bit             cap;
    bit             drop;
    logic [EW-1:0]  e;
    logic [EW-1:0]  head;
    logic [TSW-1:0] tsv;
    if (rand_mode) begin
      rd_ready = 1'($urandom_range(0, 1));
      fifo_clr = ($urandom_range(0, 39) == 0);
      ovf_clr  = ($urandom_range(0, 39) == 0);
    end
    sz   = exp_q.size();
    head = '0;
    if (sz != 0) head = exp_q[0];
    check("level", level, sz);
    check("rd_valid", rd_valid, sz != 0);
    check("rd_data", rd_data, head);
    check("ovf", ovf, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    pop  = (sz != 0) && rd_ready;
    ch   = end_now ? first_hit(t_addr, t_wr) : -1;
    cap  = end_now && mon_en && (ch >= 0);
    tsv  = TSW'(cyc);
    if (end_now) last_e_ts = cyc % (1 << TSW);
    e    = {ch[CHW-1:0], t_wr, tsv, t_addr, t_data};
    drop = 1'b0;
    if (fifo_clr) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (cap) begin
        if (sz < DEPTH || pop) exp_q.push_back(e);
        else drop = 1'b1;
      end
    end
    if (ovf_clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    @(posedge up_clk);
    @(negedge up_clk);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      up_csn     = 1'b1;
      up_wbe     = 1'b1;
      up_addr    = AW'($urandom);
      up_data_io = $urandom;
      step();
    end
  endtask

  task automatic xfer(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int nlow, bit rdy_end);
    for (int i = 0; i < nlow; i++) begin
      up_csn = 1'b0;
      up_wbe = !wr;
      if (i == nlow - 1) begin
        up_addr    = a;
        up_data_io = d;
      end else begin
        up_addr    = AW'($urandom);
        up_data_io = $urandom;
      end
      step();
    end
    up_csn     = 1'b1;
    up_wbe     = 1'b1;
    up_addr    = AW'($urandom);
    up_data_io = $urandom;
    t_wr       = wr;
    t_addr     = a;
    t_data     = d;
    end_now    = 1'b1;
    if (rdy_end) rd_ready = 1'b1;
    step();
    end_now = 1'b0;
    if (rdy_end) rd_ready = 1'b0;
  endtask

  task automatic assert_reset();
    up_rst = 1'b1;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(posedge up_clk);
    @(negedge up_clk);
    up_rst = 1'b0;
  endtask

  initial begin
    logic [TSW-1:0] ts1;
    logic [TSW-1:0] ts2;
    logic [TSW-1:0] dts;
    tests      = 0;
    fails      = 0;
    end_now    = 1'b0;
    rand_mode  = 1'b0;
    up_rst     = 1'b1;
    up_csn     = 1'b1;
    up_wbe     = 1'b1;
    up_addr    = '0;
    up_data_io = '0;
    mon_en     = 1'b1;
    fifo_clr   = 1'b0;
    ovf_clr    = 1'b0;
    rd_ready   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      t_lo[k] = '0; t_hi[k] = '0; t_mode[k] = 2'b00;
    end
    set_trig();

    vecs[0] = '{wr: 1'b0, addr: 14'h0040, data: 32'h1111_0000, exp_valid: 1'b1, exp_chan: 2'd1};
    vecs[1] = '{wr: 1'b1, addr: 14'h0040, data: 32'h2222_0000, exp_valid: 1'b1, exp_chan: 2'd2};
    vecs[2] = '{wr: 1'b1, addr: 14'h0100, data: 32'h3333_0000, exp_valid: 1'b0, exp_chan: 2'd0};
    vecs[3] = '{wr: 1'b0, addr: 14'h0100, data: 32'h4444_0000, exp_valid: 1'b0, exp_chan: 2'd0};
    vecs[4] = '{wr: 1'b0, addr: 14'h00FF, data: 32'h5555_0000, exp_valid: 1'b1, exp_chan: 2'd1};
    vecs[5] = '{wr: 1'b1, addr: 14'h0000, data: 32'h6666_0000, exp_valid: 1'b1, exp_chan: 2'd2};

    repeat (2) @(negedge up_clk);
    assert_reset();
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_level", level, 0);
    check("reset_ovf", ovf, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    idle(2);

    // Single write on channel 0.
    t_lo[0] = 14'h0010; t_hi[0] = 14'h001F; t_mode[0] = 2'b01;
    set_trig();
    xfer(1'b1, 14'h0012, 32'hDEADBEEF, 3, 1'b0);
    check("single_valid", rd_valid, 1);
    check("single_chan", rd_data[CH_LSB +: CHW], 0);
    check("single_wr", rd_data[WR_BIT], 1);
    check("single_ts", rd_data[TS_LSB +: TSW], last_e_ts);
    check("single_addr", rd_data[DW +: AW], 14'h0012);
    check("single_data", rd_data[DW-1:0], 32'hDEADBEEF);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    idle(1);

    // Overlapping channels with direction filtering.
    t_mode[0] = 2'b00;
    t_lo[1] = 14'h0000; t_hi[1] = 14'h00FF; t_mode[1] = 2'b10;
    t_lo[2] = 14'h0000; t_hi[2] = 14'h00FF; t_mode[2] = 2'b11;
    set_trig();
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, 2, 1'b0);
      check("tbl_valid", rd_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check("tbl_chan", rd_data[CH_LSB +: CHW], vecs[i].exp_chan);
        check("tbl_wr", rd_data[WR_BIT], vecs[i].wr);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
      end
      idle(1);
    end

    // Overflow: 20 captures into 16 entries, then drain and clear.
    t_lo[0] = 14'h0010; t_hi[0] = 14'h001F; t_mode[0] = 2'b01;
    t_mode[1] = 2'b00; t_mode[2] = 2'b00;
    set_trig();
    for (int i = 0; i < 20; i++) xfer(1'b1, AW'(16 + i % 16), $urandom, 1, 1'b0);
    check("ovfl_level", level, 16);
    check("ovfl_ovf", ovf, 1);
    check("ovfl_drop_cnt", drop_cnt, 4);
    rd_ready = 1'b1;
    repeat (16) step();
    rd_ready = 1'b0;
    check("drain_level", level, 0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovfclr_ovf", ovf, 0);
    check("ovfclr_drop_cnt", drop_cnt, 0);

    // Full FIFO with a pop in the end cycle of a capture.
    for (int i = 0; i < 16; i++) xfer(1'b1, AW'(16 + i), $urandom, 1, 1'b0);
    check("full_level", level, 16);
    xfer(1'b1, 14'h0015, 32'hCAFE_F00D, 2, 1'b1);
    check("fullpop_level", level, 16);
    check("fullpop_drop_cnt", drop_cnt, 0);
    check("fullpop_ovf", ovf, 0);
    rd_ready = 1'b1;
    repeat (16) step();
    rd_ready = 1'b0;
    check("fullpop_drain_level", level, 0);

    // Timestamp wrap: two captures 10 cycles apart straddling 15 -> 0.
    for (int n = 0; n < 40 && (cyc % 16) != 11; n++) idle(1);
    xfer(1'b1, 14'h0011, 32'h0000_0001, 1, 1'b0);
    idle(8);
    xfer(1'b1, 14'h0012, 32'h0000_0002, 1, 1'b0);
    ts1 = rd_data[TS_LSB +: TSW];
    rd_ready = 1'b1; step();
    ts2 = rd_data[TS_LSB +: TSW];
    step(); rd_ready = 1'b0;
    dts = ts2 - ts1;
    check("ts_first", ts1, 12);
    check("ts_delta", dts, 10);

    // Reset while csn is low; the tail of that access must be ignored.
    t_mode[0] = 2'b11; set_trig();
    up_csn = 1'b0; up_wbe = 1'b0; up_addr = 14'h0013; up_data_io = 32'h0BAD_0BAD;
    step(); step();
    assert_reset();
    step(); step();
    up_csn = 1'b1; up_wbe = 1'b1;
    step();
    idle(2);
    check("rstmid_level", level, 0);
    xfer(1'b1, 14'h0014, 32'h1234_5678, 2, 1'b0);
    check("rstmid_next_valid", rd_valid, 1);
    check("rstmid_next_addr", rd_data[DW +: AW], 14'h0014);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;

    // Random traffic against the model.
    rand_mode = 1'b1;
    for (int i = 0; i < 160; i++) begin
      if (i % 25 == 0) begin
        for (int k = 0; k < NCH; k++) begin
          t_lo[k]   = AW'($urandom_range(0, 60));
          t_hi[k]   = AW'($urandom_range(0, 80));
          t_mode[k] = 2'($urandom_range(0, 3));
        end
        set_trig();
      end
      mon_en = ($urandom_range(0, 7) != 0);
      xfer(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 80)),
           $urandom, $urandom_range(1, 3), 1'b0);
      idle($urandom_range(0, 2));
    end
    rand_mode = 1'b0;
    fifo_clr  = 1'b0;
    ovf_clr   = 1'b0;
    rd_ready  = 1'b1;
    idle(20);
    check("final_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
